// File: rtl/resource_response_buffer_if.sv
// Handshake bundle between the shared resource, the request stage and the consumer.
// The slave modport is the response buffer; the master modport is its environment.
interface resource_response_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_flush;
  logic              req_issued;
  logic [DATA_W-1:0] resource_output;
  logic              in_valid_from_resource;
  logic              consumer_ready;
  logic [DATA_W-1:0] pipeline_output;
  logic              out_valid_to_consumer;
  logic              out_stall;
  logic [CNT_W-1:0]  occupancy;
  logic              err_sticky;

  modport master (
    output in_flush, req_issued, resource_output, in_valid_from_resource, consumer_ready,
    input  pipeline_output, out_valid_to_consumer, out_stall, occupancy, err_sticky
  );

  modport slave (
    input  in_flush, req_issued, resource_output, in_valid_from_resource, consumer_ready,
    output pipeline_output, out_valid_to_consumer, out_stall, occupancy, err_sticky
  );
endinterface

// File: rtl/resource_response_buffer.sv
// Result FIFO behind the shared resource with credit-based stall toward the request stage.
// Optional RESP_BUF_BYPASS_EN: zero-latency bypass of the FIFO when it is empty.
module resource_response_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic                        clk,
  input logic                        reset,
  resource_response_buffer_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  occ_r, outst_r, drop_r;
  logic              err_r;

  logic              empty_s, full_s, drop_mode_s, resp_s;
  logic              bypass_s, byp_take_s, rd_s, wr_s, unexp_s, ovf_s;
  logic [CNT_W-1:0]  occ_n_s, outst_n_s, drop_n_s;
  logic              err_n_s;

  // Handshake decode: which of read/write/bypass/error happen this cycle.
  always_comb begin
    empty_s     = (occ_r == CNT_W'(1'b0));
    full_s      = (occ_r == CNT_W'(DEPTH));
    drop_mode_s = (drop_r != CNT_W'(1'b0));
    resp_s      = bus.in_valid_from_resource & ~drop_mode_s;
`ifdef RESP_BUF_BYPASS_EN
    // Bypass is masked in reset and flush so neither can leak a valid to the consumer.
    bypass_s    = reset & ~bus.in_flush & empty_s & resp_s;
    byp_take_s  = bypass_s & bus.consumer_ready;
`else
    bypass_s    = 1'b0;
    byp_take_s  = 1'b0;
`endif
    rd_s        = ~empty_s & bus.consumer_ready & ~bus.in_flush;
    wr_s        = resp_s & ~byp_take_s & (~full_s | rd_s) & ~bus.in_flush;
    unexp_s     = resp_s & (outst_r == CNT_W'(1'b0));
    ovf_s       = resp_s & full_s & ~rd_s;
  end

  // Next-state for occupancy, credit and drop counters; flush overrides read/write.
  always_comb begin
    occ_n_s   = occ_r;
    outst_n_s = outst_r;
    drop_n_s  = drop_r;
    err_n_s   = err_r;
    if (bus.in_flush) begin
      occ_n_s   = CNT_W'(1'b0);
      outst_n_s = CNT_W'(bus.req_issued);
      if (bus.in_valid_from_resource && (outst_r != CNT_W'(1'b0))) begin
        drop_n_s = outst_r - CNT_W'(1'b1);
      end else begin
        drop_n_s = outst_r;
      end
    end else begin
      occ_n_s   = occ_r + CNT_W'(wr_s) - CNT_W'(rd_s);
      outst_n_s = outst_r + CNT_W'(bus.req_issued)
                - CNT_W'(resp_s && (outst_r != CNT_W'(1'b0)));
      if (drop_mode_s && bus.in_valid_from_resource) begin
        drop_n_s = drop_r - CNT_W'(1'b1);
      end else begin
        drop_n_s = drop_r;
      end
      err_n_s = err_r | unexp_s | ovf_s;
    end
  end

  // Pointer, counter and error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_W'(1'b0);
      rd_ptr_r <= PTR_W'(1'b0);
      occ_r    <= CNT_W'(1'b0);
      outst_r  <= CNT_W'(1'b0);
      drop_r   <= CNT_W'(1'b0);
      err_r    <= 1'b0;
    end else begin
      occ_r    <= occ_n_s;
      outst_r  <= outst_n_s;
      drop_r   <= drop_n_s;
      err_r    <= err_n_s;
      if (bus.in_flush) begin
        rd_ptr_r <= wr_ptr_r;
      end else begin
        if (wr_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
        end
        if (rd_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
        end
      end
    end
  end

  // Storage array; unreset because empty entries are never presented.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= bus.resource_output;
    end
  end

  // Consumer-side view and credit stall, all derived from registered state (plus bypass).
  always_comb begin
    bus.out_valid_to_consumer = ~empty_s | bypass_s;
    if (bypass_s) begin
      bus.pipeline_output = bus.resource_output;
    end else if (empty_s) begin
      bus.pipeline_output = {DATA_W{1'b0}};
    end else begin
      bus.pipeline_output = mem_r[rd_ptr_r];
    end
    bus.out_stall  = ({1'b0, outst_r} + {1'b0, occ_r}) >= (CNT_W + 1)'(DEPTH);
    bus.occupancy  = occ_r;
    bus.err_sticky = err_r;
  end
endmodule

// File: tb/tb_resource_response_buffer.sv
// Randomized scoreboard bench for resource_response_buffer; the reference model tracks
// outstanding/drop counts and a queue of accepted results, and a negedge monitor checks outputs.
module tb_resource_response_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef RESP_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  resource_response_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  resource_response_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state, as seen between two rising edges.
  logic [31:0] sb_q[$];
  int m_occ = 0, m_out = 0, m_drop = 0;
  bit m_err = 1'b0;
  int n_occ, n_out, n_drop;
  bit n_err;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every visible output against the model and pop on each handshake.
  bit mon_v;
  always @(negedge clk) begin
    if (chk_en) begin
      mon_v = (m_occ != 0) || (BYP && (m_drop == 0) && bus.in_valid_from_resource && !bus.in_flush);
      check("valid", bus.out_valid_to_consumer, mon_v);
      check("occupancy", bus.occupancy, m_occ);
      check("stall", bus.out_stall, (m_out + m_occ) >= DEPTH);
      check("err_sticky", bus.err_sticky, m_err);
      if (bus.out_valid_to_consumer && bus.consumer_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_extra: got %0h expected no output at %0t", bus.pipeline_output, $time);
        end else begin
          check("data", bus.pipeline_output, sb_q.pop_front());
        end
      end
    end
  end

  // Apply one cycle of inputs and derive the model's effect from the behavioural rules.
  task automatic drive(input bit flush, input bit req, input bit vld, input logic [31:0] d, input bit rdy);
    bit rd, wr, take;
    bus.in_flush = flush;
    bus.req_issued = req;
    bus.in_valid_from_resource = vld;
    bus.resource_output = d;
    bus.consumer_ready = rdy;
    rd = (m_occ > 0) && rdy && !flush;
    take = BYP && !flush && (m_occ == 0) && (m_drop == 0) && vld && rdy;
    wr = 1'b0;
    n_err = m_err;
    if (flush) begin
      sb_q.delete();
      n_occ = 0;
      n_drop = (vld && m_out > 0) ? m_out - 1 : m_out;
      n_out = req ? 1 : 0;
    end else begin
      n_drop = m_drop;
      n_out = m_out;
      if (vld && m_drop > 0) begin
        n_drop = m_drop - 1;
      end else if (vld) begin
        if (m_out == 0) n_err = 1'b1;
        else n_out = m_out - 1;
        if (take) begin
          sb_q.push_back(d);
        end else if (m_occ < DEPTH || rd) begin
          sb_q.push_back(d);
          wr = 1'b1;
        end else begin
          n_err = 1'b1;
        end
      end
      if (req) n_out = n_out + 1;
      n_occ = m_occ + int'(wr) - int'(rd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m_occ = n_occ;
    m_out = n_out;
    m_drop = n_drop;
    m_err = n_err;
  endtask

  task automatic cycle(input bit flush, input bit req, input bit vld, input logic [31:0] d, input bit rdy);
    drive(flush, req, vld, d, rdy);
    step();
  endtask

  // Hold reset with random inputs, check everything reads zero, then release into idle.
  task automatic do_reset();
    chk_en = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_flush = 1'($urandom);
      bus.req_issued = 1'($urandom);
      bus.in_valid_from_resource = 1'($urandom);
      bus.resource_output = $urandom;
      bus.consumer_ready = 1'($urandom);
      @(negedge clk);
      check("rst_valid", bus.out_valid_to_consumer, 1'b0);
      check("rst_data", bus.pipeline_output, 32'h0);
      check("rst_stall", bus.out_stall, 1'b0);
      check("rst_occ", bus.occupancy, 3'd0);
      check("rst_err", bus.err_sticky, 1'b0);
    end
    bus.in_flush = 1'b0;
    bus.req_issued = 1'b0;
    bus.in_valid_from_resource = 1'b0;
    bus.resource_output = 32'h0;
    bus.consumer_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb_q.delete();
    m_occ = 0; m_out = 0; m_drop = 0; m_err = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fl, rq, vl, rd;
    do_reset();

    // Credit stall and in-order drain.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t2_stall_after_4_req", bus.out_stall, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0);
    check("t2_occ_full", bus.occupancy, 3'd4);
    check("t2_stall_full", bus.out_stall, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_drained", 32'(sb_q.size()), 32'd0);

    // Streaming through pointer wrap.
    for (int i = 0; i <= 10; i++) cycle(1'b0, i < 10, i > 0, 32'hB00 + 32'(i), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_drained", 32'(sb_q.size()), 32'd0);
    check("t3_err", bus.err_sticky, 1'b0);

    // Flush with two in flight and one buffered.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hC0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_occ_after_flush", bus.occupancy, 3'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'hC1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'hC2, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'hC3, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_drained", 32'(sb_q.size()), 32'd0);
    check("t4_err", bus.err_sticky, 1'b0);

    // Randomized traffic with credits honoured.
    for (int i = 0; i < 800; i++) begin
      rd = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 39) == 0);
      rq = ((m_out + m_occ) < DEPTH) && ($urandom_range(0, 1) == 1);
      vl = ((m_out + m_drop) > 0) && ($urandom_range(0, 2) != 0);
      if (fl) rd = 1'b0;
      cycle(fl, rq, vl, $urandom, rd);
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rand_drained", 32'(sb_q.size()), 32'd0);

    // Unexpected response: flagged, still delivered, sticky until reset.
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    check("t5_err_set", bus.err_sticky, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_err_held", bus.err_sticky, 1'b1);

    // Overflow: requester ignores stall, fifth response is lost.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 32'hD0 + 32'(i), 1'b0);
    check("ovf_err", bus.err_sticky, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("ovf_drained", 32'(sb_q.size()), 32'd0);

    // Same-cycle visibility of a response into an empty FIFO.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h1234, 1'b1);
    #1;
    check("t6_same_cycle_valid", bus.out_valid_to_consumer, BYP);
    check("t6_same_cycle_occ", bus.occupancy, 3'd0);
    step();
    check("t6_next_occ", bus.occupancy, BYP ? 3'd0 : 3'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_drained", 32'(sb_q.size()), 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
